// File: rtl/fir_tap_loader.sv
// Double-buffered FIR coefficient loader: beats fill a shadow bank, which is
// copied to the active bank in one step once a full set has arrived.
//
// state  | meaning
// IDLE   | waiting for i_start; active bank drives o_taps
// LOAD   | accepting beats into the shadow bank
// COMMIT | one cycle: shadow bank copied to active bank
module fir_tap_loader #(
  parameter int NTAPS = 41,
  parameter int TW    = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic                 i_coef_valid,
  input  logic signed [TW-1:0] i_coef,
  output logic                 o_coef_ready,
  output logic [NTAPS*TW-1:0]  o_taps,
  output logic                 o_taps_valid,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_error
);

  localparam int CW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NTAPS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t               state;
  logic [CW-1:0]        count;
  logic signed [TW-1:0] shadow [NTAPS];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= IDLE;
      count        <= '0;
      o_coef_ready <= 1'b0;
      o_taps       <= '0;
      o_taps_valid <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_error      <= 1'b0;
      for (int k = 0; k < NTAPS; k++) shadow[k] <= '0;
    end else begin
      o_done  <= 1'b0;
      o_error <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            state        <= LOAD;
            count        <= '0;
            o_coef_ready <= 1'b1;
            o_busy       <= 1'b1;
          end
        end
        LOAD: begin
          // A restart wins over a beat arriving in the same cycle.
          if (i_start) begin
            count   <= '0;
            o_error <= 1'b1;
          end else if (i_coef_valid && o_coef_ready) begin
            shadow[count] <= i_coef;
            if (count == LAST) begin
              state        <= COMMIT;
              count        <= '0;
              o_coef_ready <= 1'b0;
            end else begin
              count <= count + CW'(1);
            end
          end
        end
        COMMIT: begin
          for (int k = 0; k < NTAPS; k++) o_taps[k*TW +: TW] <= shadow[k];
          o_taps_valid <= 1'b1;
          o_done       <= 1'b1;
          o_busy       <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          state        <= IDLE;
          count        <= '0;
          o_coef_ready <= 1'b0;
          o_busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
